// File: rtl/cache_pkg.sv
// cache_pkg: shared types and width helpers for the cache tag controller.
//   state_t  - controller FSM states
//   line_t   - per-line metadata {valid, dirty, tag}; tag is held zero-extended to TAG_MAX bits
//   idx_w / way_w / tag_w - derived widths from WAYS, TOTAL_SIZE, ADDR_W
package cache_pkg;
    localparam int TAG_MAX = 32;
    typedef enum logic [2:0] {IDLE, LOOKUP, WB, FILL, RESP} state_t;
    typedef struct packed {
        logic               valid;
        logic               dirty;
        logic [TAG_MAX-1:0] tag;
    } line_t;
    function automatic int idx_w(input int total, input int ways);
        return $clog2(total / ways);
    endfunction
    function automatic int way_w(input int ways);
        return $clog2(ways);
    endfunction
    function automatic int tag_w(input int addr_w, input int total, input int ways);
        return addr_w - idx_w(total, ways);
    endfunction
endpackage

// File: rtl/cache_tag_array.sv
// cache_tag_array: tag/valid/dirty storage, all ways of one set read combinationally.
//   clk, rst (async, active-low clear)
//   idx          - set addressed by both the read and the write port
//   rd_lines     - metadata of every way in set idx
//   wr_en/wr_way/wr_line - single write port into set idx
module cache_tag_array
    import cache_pkg::*;
#(
    parameter int SETS  = 4,
    parameter int WAYS  = 4,
    parameter int IDX_W = 2,
    parameter int WAY_W = 2
)(
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] idx,
    output line_t            rd_lines [WAYS],
    input  logic             wr_en,
    input  logic [WAY_W-1:0] wr_way,
    input  line_t            wr_line
);
    line_t mem [SETS][WAYS];
    always_ff @(posedge clk or negedge rst)
        if (!rst)
            for (int s = 0; s < SETS; s++)
                for (int w = 0; w < WAYS; w++)
                    mem[s][w] <= '0;
        else if (wr_en)
            mem[idx][wr_way] <= wr_line;
    always_comb
        for (int w = 0; w < WAYS; w++)
            rd_lines[w] = mem[idx][w];
endmodule

// File: rtl/cache_tag_ctrl.sv
// cache_tag_ctrl: set-associative lookup controller feeding the per-set LRU buffer.
//   requester: req_valid/req_ready/req_we/req_addr in, resp_valid/resp_hit/resp_way out
//   LRU touch: lru_re/lru_we/lru_way/lru_index out, lru_replace_way in
//   memory fill: mem_req_valid/mem_req_addr out, mem_req_ready in
//   writeback: wb_valid/wb_addr out, wb_ready in (active only with CACHE_WRITEBACK_EN)
//   rst is asynchronous, active-low.
module cache_tag_ctrl
    import cache_pkg::*;
#(
    parameter  int WAYS       = 4,
    parameter  int TOTAL_SIZE = 16,
    parameter  int ADDR_W     = 16,
    localparam int IDX_W      = idx_w(TOTAL_SIZE, WAYS),
    localparam int WAY_W      = way_w(WAYS),
    localparam int TAG_W      = tag_w(ADDR_W, TOTAL_SIZE, WAYS)
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              resp_valid,
    output logic              resp_hit,
    output logic [WAY_W-1:0]  resp_way,
    output logic              lru_re,
    output logic              lru_we,
    output logic [WAY_W-1:0]  lru_way,
    output logic [IDX_W-1:0]  lru_index,
    input  logic [WAY_W-1:0]  lru_replace_way,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [ADDR_W-1:0] wb_addr
);
    state_t             state;
    logic [ADDR_W-1:0]  addr_q;
    logic               we_q;
    logic [WAY_W-1:0]   victim_q, victim_c, hit_way, free_way, wr_way;
    logic               hit, has_free, touch, fill_done, wb_done, dirty_hit, fill_dirty, wb_need, wr_en;
    line_t              lines [WAYS];
    line_t              wr_line;
    logic [TAG_W-1:0]   tag_q;
    logic [IDX_W-1:0]   idx_q;
    logic [TAG_MAX-1:0] vtag;
    assign tag_q = addr_q[ADDR_W-1:IDX_W];
    assign idx_q = addr_q[IDX_W-1:0];
    assign vtag  = lines[victim_q].tag;
    cache_tag_array #(.SETS(TOTAL_SIZE / WAYS), .WAYS(WAYS), .IDX_W(IDX_W), .WAY_W(WAY_W)) u_tags (
        .clk(clk), .rst(rst), .idx(idx_q), .rd_lines(lines),
        .wr_en(wr_en), .wr_way(wr_way), .wr_line(wr_line)
    );
    // Descending scan so the lowest matching / lowest invalid way is the one left standing.
    always_comb begin
        hit      = 1'b0;
        hit_way  = '0;
        has_free = 1'b0;
        free_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (lines[w].valid && lines[w].tag == TAG_MAX'(tag_q)) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!lines[w].valid) begin
                has_free = 1'b1;
                free_way = WAY_W'(w);
            end
        end
    end
    assign victim_c      = has_free ? free_way : lru_replace_way;
    assign fill_done     = (state == FILL) && mem_req_ready;
    assign touch         = ((state == LOOKUP) && hit) || fill_done;
    assign lru_re        = touch && !we_q;
    assign lru_we        = touch && we_q;
    assign lru_way       = (state == FILL) ? victim_q : hit_way;
    assign lru_index     = idx_q;
    assign req_ready     = (state == IDLE);
    assign resp_valid    = (state == RESP);
    assign mem_req_valid = (state == FILL);
    assign mem_req_addr  = addr_q;
`ifdef CACHE_WRITEBACK_EN
    assign dirty_hit  = (state == LOOKUP) && hit && we_q;
    assign wb_done    = (state == WB) && wb_ready;
    assign fill_dirty = we_q;
    assign wb_need    = lines[victim_c].valid && lines[victim_c].dirty;
    assign wb_valid   = (state == WB);
    assign wb_addr    = wb_valid ? {vtag[TAG_W-1:0], idx_q} : '0;
`else
    logic unused_ok;
    assign unused_ok  = ^{wb_ready, lines[victim_q].dirty};
    assign dirty_hit  = 1'b0;
    assign wb_done    = 1'b0;
    assign fill_dirty = 1'b0;
    assign wb_need    = 1'b0;
    assign wb_valid   = 1'b0;
    assign wb_addr    = '0;
`endif
    // One write port serves dirty-on-write-hit, dirty clear after writeback, and the fill itself.
    assign wr_en   = fill_done || wb_done || dirty_hit;
    assign wr_way  = dirty_hit ? hit_way : victim_q;
    assign wr_line = '{valid: 1'b1,
                       dirty: dirty_hit || (fill_done && fill_dirty),
                       tag:   wb_done ? vtag : TAG_MAX'(tag_q)};
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state    <= IDLE;
            addr_q   <= '0;
            we_q     <= 1'b0;
            victim_q <= '0;
            resp_hit <= 1'b0;
            resp_way <= '0;
        end else
            case (state)
                IDLE:
                    if (req_valid) begin
                        addr_q <= req_addr;
                        we_q   <= req_we;
                        state  <= LOOKUP;
                    end
                LOOKUP:
                    if (hit) begin
                        resp_hit <= 1'b1;
                        resp_way <= hit_way;
                        state    <= RESP;
                    end else begin
                        victim_q <= victim_c;
                        state    <= wb_need ? WB : FILL;
                    end
                WB:
                    if (wb_ready) state <= FILL;
                FILL:
                    if (mem_req_ready) begin
                        resp_hit <= 1'b0;
                        resp_way <= victim_q;
                        state    <= RESP;
                    end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
endmodule

// File: tb/tb_cache_tag_ctrl.sv
// tb_cache_tag_ctrl: scoreboard-driven bench for cache_tag_ctrl (WAYS=4, 4 sets, 16-bit addresses).
module tb_cache_tag_ctrl;
`ifdef CACHE_WRITEBACK_EN
    localparam logic WB_EN = 1'b1;
`else
    localparam logic WB_EN = 1'b0;
`endif
    logic        clk = 1'b0, rst = 1'b0;
    logic        req_valid = 1'b0, req_ready, req_we = 1'b0;
    logic [15:0] req_addr = '0;
    logic        resp_valid, resp_hit;
    logic [1:0]  resp_way;
    logic        lru_re, lru_we;
    logic [1:0]  lru_way, lru_index;
    logic [1:0]  lru_replace_way = '0;
    logic        mem_req_valid, mem_req_ready = 1'b0;
    logic [15:0] mem_req_addr;
    logic        wb_valid, wb_ready = 1'b0;
    logic [15:0] wb_addr;
    logic [2:0]  exp_q [$];
    int          checks = 0, errors = 0;

    cache_tag_ctrl dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_addr(req_addr),
        .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_way(resp_way),
        .lru_re(lru_re), .lru_we(lru_we), .lru_way(lru_way), .lru_index(lru_index),
        .lru_replace_way(lru_replace_way),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // Issues one request starting at a negedge in IDLE and follows it until the response,
    // servicing writeback/fill handshakes and checking every observable along the way.
    task automatic do_req(input logic we, input logic [15:0] addr, input logic exp_hit,
                          input logic [1:0] exp_way, input int mem_wait, input logic [1:0] rep,
                          input logic exp_wb, input logic [15:0] exp_wb_addr);
        int n, mw, touches, lat;
        logic got, saw_mem, saw_wb;
        logic [2:0] e;
        n = 0; mw = 0; touches = 0; got = 1'b0; saw_mem = 1'b0; saw_wb = 1'b0;
        lat = exp_hit ? 1 : 2 + mem_wait + (exp_wb ? 1 : 0);
        exp_q.push_back({exp_hit, exp_way});
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL req_ready_idle addr=%h got=%b want=1", addr, req_ready); end
        req_valid = 1'b1; req_we = we; req_addr = addr; lru_replace_way = rep;
        @(negedge clk);
        req_valid = 1'b0;
        while (!got && n < 100) begin
            if (wb_valid) begin
                saw_wb = 1'b1;
                checks++;
                if (exp_wb !== 1'b1 || saw_mem || wb_addr !== exp_wb_addr) begin
                    errors++; $display("FAIL wb addr=%h wb_addr=%h want=%h expected_wb=%b mem_before=%b", addr, wb_addr, exp_wb_addr, exp_wb, saw_mem);
                end
                wb_ready = 1'b1;
            end else wb_ready = 1'b0;
            if (mem_req_valid) begin
                saw_mem = 1'b1;
                mem_req_ready = (mw == mem_wait);
                mw++;
                checks++;
                if (exp_hit || mem_req_addr !== addr) begin
                    errors++; $display("FAIL mem_req addr=%h mem_req_addr=%h expected_hit=%b", addr, mem_req_addr, exp_hit);
                end
            end else mem_req_ready = 1'b0;
            #1;
            if (lru_re || lru_we) begin
                touches++;
                checks++;
                if (lru_we !== we || lru_re !== !we || lru_way !== exp_way || lru_index !== addr[1:0]) begin
                    errors++; $display("FAIL lru_touch addr=%h re=%b we=%b way=%0d idx=%0d want we=%b way=%0d idx=%0d",
                                       addr, lru_re, lru_we, lru_way, lru_index, we, exp_way, addr[1:0]);
                end
            end
            if (resp_valid) begin
                got = 1'b1;
                checks++;
                if (exp_q.size() == 0) begin errors++; $display("FAIL resp_unexpected addr=%h", addr); end
                else begin
                    e = exp_q.pop_front();
                    if ({resp_hit, resp_way} !== e || n !== lat) begin
                        errors++; $display("FAIL resp addr=%h hit=%b way=%0d lat=%0d want hit=%b way=%0d lat=%0d",
                                           addr, resp_hit, resp_way, n, e[2], e[1:0], lat);
                    end
                end
            end else begin
                checks++;
                if (req_ready !== 1'b0) begin errors++; $display("FAIL req_ready_busy addr=%h got=%b want=0", addr, req_ready); end
                @(negedge clk);
                n++;
            end
        end
        mem_req_ready = 1'b0;
        wb_ready = 1'b0;
        if (!got) begin
            errors++; checks++;
            $display("FAIL resp_timeout addr=%h got=none want=resp", addr);
            void'(exp_q.pop_front());
        end
        checks++;
        if (touches !== 1 || saw_mem !== !exp_hit || saw_wb !== exp_wb) begin
            errors++; $display("FAIL req_summary addr=%h touches=%0d mem=%b wb=%b want touches=1 mem=%b wb=%b",
                               addr, touches, saw_mem, saw_wb, !exp_hit, exp_wb);
        end
        @(negedge clk);
        checks++;
        if (resp_valid !== 1'b0) begin errors++; $display("FAIL resp_one_cycle addr=%h got=%b want=0", addr, resp_valid); end
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({req_ready, resp_valid, resp_hit, resp_way, lru_re, lru_we, lru_way, lru_index, mem_req_valid, wb_valid} !== 13'h1000) begin
            errors++; $display("FAIL reset_ctrl got=%h want=1000",
                               {req_ready, resp_valid, resp_hit, resp_way, lru_re, lru_we, lru_way, lru_index, mem_req_valid, wb_valid});
        end
        checks++;
        if ({mem_req_addr, wb_addr} !== 32'h0) begin errors++; $display("FAIL reset_addr got=%h want=0", {mem_req_addr, wb_addr}); end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin errors++; $display("FAIL post_reset ready=%b resp=%b want 1 0", req_ready, resp_valid); end
    endtask

    task automatic test_cold_miss();
        do_req(1'b0, 16'h0004, 1'b0, 2'd0, 2, 2'd3, 1'b0, 16'h0);
    endtask

    task automatic test_hit();
        do_req(1'b0, 16'h0004, 1'b1, 2'd0, 0, 2'd3, 1'b0, 16'h0);
    endtask

    task automatic test_victim();
        do_req(1'b0, 16'h0008, 1'b0, 2'd1, 0, 2'd0, 1'b0, 16'h0);
        do_req(1'b0, 16'h000C, 1'b0, 2'd2, 1, 2'd0, 1'b0, 16'h0);
        do_req(1'b0, 16'h0010, 1'b0, 2'd3, 0, 2'd0, 1'b0, 16'h0);
        do_req(1'b0, 16'h0014, 1'b0, 2'd2, 0, 2'd2, 1'b0, 16'h0);
        do_req(1'b0, 16'h000C, 1'b0, 2'd1, 0, 2'd1, 1'b0, 16'h0);
        do_req(1'b0, 16'h0014, 1'b1, 2'd2, 0, 2'd0, 1'b0, 16'h0);
    endtask

    task automatic test_back_to_back();
        do_req(1'b1, 16'h0014, 1'b1, 2'd2, 0, 2'd0, 1'b0, 16'h0);
        do_req(1'b0, 16'h000C, 1'b1, 2'd1, 0, 2'd0, 1'b0, 16'h0);
        do_req(1'b0, 16'h0004, 1'b1, 2'd0, 0, 2'd0, 1'b0, 16'h0);
    endtask

    task automatic test_mem_stall();
        do_req(1'b0, 16'h0021, 1'b0, 2'd0, 10, 2'd3, 1'b0, 16'h0);
    endtask

    task automatic test_reset_mid_fill();
        req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h0022;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (mem_req_valid !== 1'b1) begin errors++; $display("FAIL fill_entered got=%b want=1", mem_req_valid); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if ({mem_req_valid, resp_valid, req_ready} !== 3'b001) begin
            errors++; $display("FAIL reset_abort mem=%b resp=%b ready=%b want 0 0 1", mem_req_valid, resp_valid, req_ready);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({mem_req_valid, resp_valid} !== 2'b00) begin errors++; $display("FAIL reset_no_resp mem=%b resp=%b want 0 0", mem_req_valid, resp_valid); end
        do_req(1'b0, 16'h0004, 1'b0, 2'd0, 0, 2'd3, 1'b0, 16'h0);
    endtask

    task automatic test_writeback();
        do_req(1'b1, 16'h0004, 1'b1, 2'd0, 0, 2'd0, 1'b0, 16'h0);
        do_req(1'b0, 16'h0008, 1'b0, 2'd1, 0, 2'd0, 1'b0, 16'h0);
        do_req(1'b0, 16'h000C, 1'b0, 2'd2, 0, 2'd0, 1'b0, 16'h0);
        do_req(1'b0, 16'h0010, 1'b0, 2'd3, 0, 2'd0, 1'b0, 16'h0);
        do_req(1'b0, 16'h0014, 1'b0, 2'd0, 1, 2'd0, WB_EN, 16'h0004);
        do_req(1'b0, 16'h0004, 1'b0, 2'd1, 0, 2'd1, 1'b0, 16'h0);
    endtask

    initial begin
        test_reset();
        test_cold_miss();
        test_hit();
        test_victim();
        test_back_to_back();
        test_mem_stall();
        test_reset_mid_fill();
        test_writeback();
        checks++;
        if (exp_q.size() !== 0) begin errors++; $display("FAIL scoreboard_left got=%0d want=0", exp_q.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end
endmodule
